fpu_fcsr_wb: RTL and testbench

Writeback and status stage that sits directly downstream of the single-precision `fmul` datapath (and future FP arithmetic units). It performs three jobs:
- Buffers each FP result together with its destination register through a valid/ready handshake.
- Accumulates the per-operation exception flags into the sticky `fflags` field.
- Holds `frm` and converts the instruction's 3-bit RISC-V rounding-mode field into the 2-bit `rm` code the FP units consume.

It also serves the `fflags`/`frm`/`fcsr` CSR accesses.

---
 rtl/fpu_fcsr_wb.sv | 228 ++++++++++++++++++++++
 tb/tb_fpu_fcsr_wb.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_fcsr_wb.sv
// ---------------------------------------------------------------------------
// fpu_fcsr_wb
//
// Writeback and status stage placed after the FP arithmetic units. It
// buffers each FP result with its destination register, accumulates the
// sticky exception flags, holds the dynamic rounding mode and serves the
// fflags / frm / fcsr CSR accesses.
//
// Build option:
//   FPU_WB_SKID_EN  defined     -> 2-entry skid buffer with registered in_ready
//                   not defined -> single output register, in_ready follows
//                                  out_ready combinationally
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   instr_rm      in  [2:0]   rounding-mode field of the instruction
//   rm            out [1:0]   code to FP units: 00 RNE, 01 RDN, 10 RUP, 11 RTZ
//   rm_illegal    out         effective rounding mode is not supported
//   in_valid/in_ready         upstream result handshake
//   in_result     in  [FLEN]  result value
//   in_rd         in  [RDW]   destination register index
//   in_nv..in_nx  in          exception flags of this operation
//   out_valid/out_ready       downstream (register file) handshake
//   out_result    out [FLEN]  buffered result
//   out_rd        out [RDW]   buffered destination index
//   csr_en        in          CSR access this cycle
//   csr_op        in  [1:0]   00 read, 01 write, 10 set, 11 clear
//   csr_addr      in  [11:0]  0x001 fflags, 0x002 frm, 0x003 fcsr
//   csr_wdata     in  [31:0]  write/set/clear operand
//   csr_rdata     out [31:0]  pre-update read data (combinational)
//   csr_illegal   out         access to an unmapped address
// ---------------------------------------------------------------------------
module fpu_fcsr_wb #(
  parameter int FLEN = 32,
  parameter int RDW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      instr_rm,
  output logic [1:0]      rm,
  output logic            rm_illegal,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [FLEN-1:0] in_result,
  input  logic [RDW-1:0]  in_rd,
  input  logic            in_nv,
  input  logic            in_dz,
  input  logic            in_of,
  input  logic            in_uf,
  input  logic            in_nx,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FLEN-1:0] out_result,
  output logic [RDW-1:0]  out_rd,
  input  logic            csr_en,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [31:0]     csr_wdata,
  output logic [31:0]     csr_rdata,
  output logic            csr_illegal
);

  localparam logic [11:0] ADDR_FFLAGS = 12'h001;
  localparam logic [11:0] ADDR_FRM    = 12'h002;
  localparam logic [11:0] ADDR_FCSR   = 12'h003;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic [4:0] fflags;
  logic [2:0] frm;
  logic [4:0] fflags_mod;
  logic [2:0] frm_mod;
  logic [4:0] in_flags;
  logic [4:0] fflags_opnd;
  logic [2:0] frm_opnd;
  logic [2:0] eff_rm;
  logic       sel_fflags;
  logic       sel_frm;
  logic       mapped;
  logic       accept;

  assign accept   = in_valid & in_ready;
  assign in_flags = {in_nv, in_dz, in_of, in_uf, in_nx};

  // Rounding-mode translation. The dynamic encoding 111 in the instruction
  // selects frm; anything outside RNE/RTZ/RDN/RUP is reported as illegal
  // and a harmless RNE code is driven so the FP unit never sees garbage.
  always_comb begin
    rm         = 2'b00;
    rm_illegal = 1'b0;
    eff_rm     = (instr_rm == 3'b111) ? frm : instr_rm;
    case (eff_rm)
      3'b000:  rm = 2'b00;
      3'b001:  rm = 2'b11;
      3'b010:  rm = 2'b01;
      3'b011:  rm = 2'b10;
      default: rm_illegal = 1'b1;
    endcase
  end

  // CSR decode, read mux and field modification. The read value is the
  // current (pre-update) state. fcsr packs frm above fflags, so its frm
  // operand comes from bits [7:5] while the frm CSR uses bits [2:0].
  always_comb begin
    sel_fflags  = (csr_addr == ADDR_FFLAGS) || (csr_addr == ADDR_FCSR);
    sel_frm     = (csr_addr == ADDR_FRM)    || (csr_addr == ADDR_FCSR);
    mapped      = sel_fflags | sel_frm;
    csr_illegal = csr_en & ~mapped;
    fflags_opnd = csr_wdata[4:0];
    frm_opnd    = (csr_addr == ADDR_FCSR) ? csr_wdata[7:5] : csr_wdata[2:0];
    fflags_mod  = fflags;
    frm_mod     = frm;
    csr_rdata   = 32'd0;

    case (csr_addr)
      ADDR_FFLAGS: csr_rdata = {27'd0, fflags};
      ADDR_FRM:    csr_rdata = {29'd0, frm};
      ADDR_FCSR:   csr_rdata = {24'd0, frm, fflags};
      default:     csr_rdata = 32'd0;
    endcase

    if (csr_en && mapped) begin
      case (csr_op)
        OP_WRITE: begin
          if (sel_fflags) fflags_mod = fflags_opnd;
          if (sel_frm)    frm_mod    = frm_opnd;
        end
        OP_SET: begin
          if (sel_fflags) fflags_mod = fflags | fflags_opnd;
          if (sel_frm)    frm_mod    = frm | frm_opnd;
        end
        OP_CLEAR: begin
          if (sel_fflags) fflags_mod = fflags & ~fflags_opnd;
          if (sel_frm)    frm_mod    = frm & ~frm_opnd;
        end
        default: ;
      endcase
    end
  end

  // Status register update. Flags of an accepted operation are OR-ed in
  // after the CSR modification so a simultaneous clear can never drop them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fflags <= 5'd0;
      frm    <= 3'd0;
    end else begin
      fflags <= fflags_mod | (accept ? in_flags : 5'd0);
      frm    <= frm_mod;
    end
  end

`ifdef FPU_WB_SKID_EN
  logic [FLEN-1:0] mem_result [2];
  logic [RDW-1:0]  mem_rd     [2];
  logic            wptr;
  logic            rptr;
  logic [1:0]      count;
  logic [1:0]      count_next;
  logic            in_ready_q;
  logic            pop;

  assign pop        = out_valid & out_ready;
  assign count_next = count + 2'(accept) - 2'(pop);
  assign in_ready   = in_ready_q;
  assign out_valid  = (count != 2'd0);
  assign out_result = mem_result[rptr];
  assign out_rd     = mem_rd[rptr];

  // Two-entry skid FIFO. in_ready is registered from the next occupancy so
  // it never depends combinationally on out_ready; it comes up one cycle
  // after reset release. Entries are cleared on reset so the outputs read
  // zero while the buffer is empty after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mem_result[i] <= '0;
        mem_rd[i]     <= '0;
      end
      wptr       <= 1'b0;
      rptr       <= 1'b0;
      count      <= 2'd0;
      in_ready_q <= 1'b0;
    end else begin
      if (accept) begin
        mem_result[wptr] <= in_result;
        mem_rd[wptr]     <= in_rd;
        wptr             <= ~wptr;
      end
      if (pop) begin
        rptr <= ~rptr;
      end
      count      <= count_next;
      in_ready_q <= (count_next != 2'd2);
    end
  end
`else
  logic            valid_q;
  logic [FLEN-1:0] result_q;
  logic [RDW-1:0]  rd_q;

  assign in_ready   = ~rst & (~valid_q | out_ready);
  assign out_valid  = valid_q;
  assign out_result = result_q;
  assign out_rd     = rd_q;

  // Single output register. A new result may replace the held one in the
  // same cycle it is consumed, which keeps one result per cycle while
  // backpressure reaches in_ready immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
    end else if (accept) begin
      valid_q  <= 1'b1;
      result_q <= in_result;
      rd_q     <= in_rd;
    end else if (out_ready) begin
      valid_q  <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_fpu_fcsr_wb.sv
// ---------------------------------------------------------------------------
// tb_fpu_fcsr_wb
//
// Directed self-checking bench for fpu_fcsr_wb: reset state, result
// buffering, flag accumulation, CSR access, rounding-mode mapping,
// backpressure and reset in the middle of a transfer. Works for both
// builds (FPU_WB_SKID_EN defined or not).
// ---------------------------------------------------------------------------
module tb_fpu_fcsr_wb;

  logic        clk;
  logic        rst;
  logic [2:0]  instr_rm;
  logic [1:0]  rm;
  logic        rm_illegal;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [4:0]  in_rd;
  logic        in_nv, in_dz, in_of, in_uf, in_nx;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        csr_en;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;

  int vectorCount = 0;
  int missCount   = 0;

  fpu_fcsr_wb #(.FLEN(32), .RDW(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_rm   (instr_rm),
    .rm         (rm),
    .rm_illegal (rm_illegal),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_rd      (in_rd),
    .in_nv      (in_nv),
    .in_dz      (in_dz),
    .in_of      (in_of),
    .in_uf      (in_uf),
    .in_nx      (in_nx),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .csr_en     (csr_en),
    .csr_op     (csr_op),
    .csr_addr   (csr_addr),
    .csr_wdata  (csr_wdata),
    .csr_rdata  (csr_rdata),
    .csr_illegal(csr_illegal)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] res,
                               input logic [4:0] rd, input logic [4:0] flags);
    in_valid  = v;
    in_result = res;
    in_rd     = rd;
    {in_nv, in_dz, in_of, in_uf, in_nx} = flags;
  endtask

  task automatic csrAccess(input logic en, input logic [1:0] op,
                           input logic [11:0] addr, input logic [31:0] wdata);
    csr_en    = en;
    csr_op    = op;
    csr_addr  = addr;
    csr_wdata = wdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    assert (observed === expected)
      else begin
        missCount++;
        $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
      end
  endtask

  logic [31:0] bpRes [3];
  logic [4:0]  bpRd  [3];
  logic        expReady [3];
  int          expAccepted;
  int          inIdx;
  int          outIdx;

  initial begin
    bpRes[0] = 32'hA000_0001; bpRd[0] = 5'd11;
    bpRes[1] = 32'hA000_0002; bpRd[1] = 5'd12;
    bpRes[2] = 32'hA000_0003; bpRd[2] = 5'd13;
`ifdef FPU_WB_SKID_EN
    expReady[0] = 1'b1; expReady[1] = 1'b1; expReady[2] = 1'b0;
    expAccepted = 2;
`else
    expReady[0] = 1'b1; expReady[1] = 1'b0; expReady[2] = 1'b0;
    expAccepted = 1;
`endif

    rst       = 1'b0;
    instr_rm  = 3'b001;
    out_ready = 1'b0;
    applyStimulus(1'b0, 32'd0, 5'd0, 5'd0);
    csrAccess(1'b0, 2'b00, 12'h000, 32'd0);

    // ---- Reset state ----
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_out_valid",  32'(out_valid),  32'd0);
    checkOutput("rst_in_ready",   32'(in_ready),   32'd0);
    checkOutput("rst_out_result", out_result,      32'd0);
    checkOutput("rst_out_rd",     32'(out_rd),     32'd0);
    checkOutput("rst_rm",         32'(rm),         32'd3);
    checkOutput("rst_rm_illegal", 32'(rm_illegal), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    tick();
    checkOutput("idle_in_ready",  32'(in_ready),  32'd1);
    checkOutput("idle_out_valid", 32'(out_valid), 32'd0);

    // ---- Plain result ----
    out_ready = 1'b1;
    applyStimulus(1'b1, 32'h4010_0000, 5'd5, 5'b00000);
    #1;
    checkOutput("plain_in_ready", 32'(in_ready), 32'd1);
    checkOutput("plain_no_bypass", 32'(out_valid), 32'd0);
    tick();
    applyStimulus(1'b0, 32'd0, 5'd0, 5'd0);
    csrAccess(1'b1, 2'b00, 12'h001, 32'd0);
    #1;
    checkOutput("plain_out_valid",  32'(out_valid), 32'd1);
    checkOutput("plain_out_result", out_result,     32'h4010_0000);
    checkOutput("plain_out_rd",     32'(out_rd),    32'd5);
    checkOutput("plain_fflags",     csr_rdata,      32'h00);
    tick();
    checkOutput("plain_drained", 32'(out_valid), 32'd0);

    // ---- Overflow and underflow flags ----
    applyStimulus(1'b1, 32'h7F80_0000, 5'd6, 5'b00101);
    tick();
    applyStimulus(1'b0, 32'd0, 5'd0, 5'd0);
    #1;
    checkOutput("of_out_result", out_result, 32'h7F80_0000);
    checkOutput("of_fflags",     csr_rdata,  32'h05);
    applyStimulus(1'b1, 32'h0000_0000, 5'd7, 5'b00011);
    tick();
    applyStimulus(1'b0, 32'd0, 5'd0, 5'd0);
    #1;
    checkOutput("uf_fflags", csr_rdata, 32'h07);

    // Flags presented without in_valid must be ignored.
    applyStimulus(1'b0, 32'h1234_5678, 5'd8, 5'b01000);
    tick();
    applyStimulus(1'b0, 32'd0, 5'd0, 5'd0);
    #1;
    checkOutput("ignored_flags", csr_rdata, 32'h07);

    // ---- Invalid, then clear together with an accepted NX ----
    csrAccess(1'b1, 2'b01, 12'h001, 32'd0);
    tick();
    applyStimulus(1'b1, 32'h7FC0_0000, 5'd9, 5'b10000);
    csrAccess(1'b1, 2'b00, 12'h001, 32'd0);
    #1;
    checkOutput("nv_pre_update", csr_rdata, 32'h00);
    tick();
    applyStimulus(1'b0, 32'd0, 5'd0, 5'd0);
    #1;
    checkOutput("nv_fflags", csr_rdata, 32'h10);
    applyStimulus(1'b1, 32'h3F80_0000, 5'd10, 5'b00001);
    csrAccess(1'b1, 2'b11, 12'h001, 32'h10);
    #1;
    checkOutput("clr_pre_update", csr_rdata, 32'h10);
    tick();
    applyStimulus(1'b0, 32'd0, 5'd0, 5'd0);
    csrAccess(1'b1, 2'b00, 12'h001, 32'd0);
    #1;
    checkOutput("clr_nx_fflags", csr_rdata, 32'h01);

    // ---- Rounding modes ----
    instr_rm = 3'b111;
    csrAccess(1'b1, 2'b01, 12'h002, 32'hFFFF_FFFB);
    #1;
    checkOutput("rm_before_write", 32'(rm), 32'd0);
    tick();
    csrAccess(1'b1, 2'b00, 12'h002, 32'd0);
    #1;
    checkOutput("frm_write_upper_ignored", csr_rdata, 32'd3);
    checkOutput("rm_dyn_rup",         32'(rm),         32'd2);
    checkOutput("rm_dyn_rup_illegal", 32'(rm_illegal), 32'd0);
    instr_rm = 3'b001;
    #1;
    checkOutput("rm_static_rtz", 32'(rm), 32'd3);
    instr_rm = 3'b010;
    #1;
    checkOutput("rm_static_rdn", 32'(rm), 32'd1);
    instr_rm = 3'b101;
    #1;
    checkOutput("rm_101_illegal", 32'(rm_illegal), 32'd1);
    checkOutput("rm_101_code",    32'(rm),         32'd0);
    csrAccess(1'b1, 2'b01, 12'h002, 32'd4);
    tick();
    instr_rm = 3'b111;
    csrAccess(1'b1, 2'b00, 12'h003, 32'd0);
    #1;
    checkOutput("rm_rmm_illegal", 32'(rm_illegal), 32'd1);
    checkOutput("rm_rmm_code",    32'(rm),         32'd0);
    checkOutput("fcsr_read",      csr_rdata,       32'h81);

    // fcsr write splits into frm=001, fflags=00101.
    csrAccess(1'b1, 2'b01, 12'h003, 32'hFFFF_FF25);
    tick();
    csrAccess(1'b1, 2'b00, 12'h002, 32'd0);
    #1;
    checkOutput("fcsr_write_frm", csr_rdata, 32'd1);
    checkOutput("rm_dyn_rtz",     32'(rm),   32'd3);
    csrAccess(1'b1, 2'b10, 12'h002, 32'd2);
    tick();
    csrAccess(1'b1, 2'b00, 12'h002, 32'd0);
    #1;
    checkOutput("frm_set", csr_rdata, 32'd3);

    // Unmapped address: flagged, reads zero, changes nothing.
    csrAccess(1'b1, 2'b01, 12'h004, 32'h0000_00FF);
    #1;
    checkOutput("unmapped_illegal", 32'(csr_illegal), 32'd1);
    checkOutput("unmapped_rdata",   csr_rdata,        32'd0);
    tick();
    csrAccess(1'b1, 2'b00, 12'h003, 32'd0);
    #1;
    checkOutput("mapped_not_illegal", 32'(csr_illegal), 32'd0);
    checkOutput("unmapped_no_change", csr_rdata,        32'h65);
    csrAccess(1'b0, 2'b00, 12'h000, 32'd0);

    // ---- Backpressure ----
    out_ready = 1'b0;
    inIdx = 0;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, bpRes[inIdx], bpRd[inIdx], 5'd0);
      #1;
      checkOutput($sformatf("bp_in_ready_%0d", c), 32'(in_ready), 32'(expReady[c]));
      if (in_ready && inIdx < 2) inIdx++;
      tick();
    end
    checkOutput("bp_accepted",    inIdx,           expAccepted);
    checkOutput("bp_hold_valid",  32'(out_valid),  32'd1);
    checkOutput("bp_hold_result", out_result,      bpRes[0]);
    checkOutput("bp_hold_rd",     32'(out_rd),     32'(bpRd[0]));

    out_ready = 1'b1;
    outIdx = 0;
    for (int c = 0; c < 20 && outIdx < 3; c++) begin
      if (inIdx < 3) applyStimulus(1'b1, bpRes[inIdx], bpRd[inIdx], 5'd0);
      else           applyStimulus(1'b0, 32'd0, 5'd0, 5'd0);
      #1;
      if (out_valid) begin
        checkOutput($sformatf("bp_order_result_%0d", outIdx), out_result, bpRes[outIdx]);
        checkOutput($sformatf("bp_order_rd_%0d", outIdx), 32'(out_rd), 32'(bpRd[outIdx]));
        outIdx++;
      end
      if (in_valid && in_ready) inIdx++;
      tick();
    end
    applyStimulus(1'b0, 32'd0, 5'd0, 5'd0);
    #1;
    checkOutput("bp_all_delivered", outIdx,         3);
    checkOutput("bp_no_duplicate",  32'(out_valid), 32'd0);

    // ---- Reset with results buffered ----
    out_ready = 1'b0;
    applyStimulus(1'b1, 32'hDEAD_BEEF, 5'd20, 5'd0);
    tick();
    applyStimulus(1'b1, 32'hCAFE_F00D, 5'd21, 5'd0);
    tick();
    applyStimulus(1'b0, 32'd0, 5'd0, 5'd0);
    #1;
    checkOutput("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    csrAccess(1'b1, 2'b00, 12'h003, 32'd0);
    #1;
    checkOutput("mid_rst_out_valid",  32'(out_valid), 32'd0);
    checkOutput("mid_rst_in_ready",   32'(in_ready),  32'd0);
    checkOutput("mid_rst_out_result", out_result,     32'd0);
    checkOutput("mid_rst_fcsr",       csr_rdata,      32'd0);
    #3 rst = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    checkOutput("post_rst_discarded", 32'(out_valid), 32'd0);
    checkOutput("post_rst_in_ready",  32'(in_ready),  32'd1);
    csrAccess(1'b0, 2'b00, 12'h000, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
